// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: buffer state and the flag-annotated result word.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } res_state_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] z;
    logic                 overFlow;
    logic                 zero;
    logic                 neg;
  } alu_result_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Packs an adder sum and overflow bit into a result word with zero/negative flags.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] inZ,
  input  logic                 inOverFlow,
  output alu_result_t          result
);

  always_comb begin
    result          = '0;
    result.z        = inZ;
    result.overFlow = inOverFlow;
    result.zero     = (inZ == '0);
    result.neg      = inZ[ALU_WIDTH-1];
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage after the adder: 2-entry skid buffer, flags, sticky overflow, counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = ALU_WIDTH,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [WIDTH-1:0]     inZ,
  input  logic                 inOverFlow,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH-1:0]     outZ,
  output logic                 outOverFlow,
  output logic                 outZero,
  output logic                 outNeg,
  input  logic                 clrSticky,
  output logic                 stickyOverFlow,
  output logic [CNT_WIDTH-1:0] opCount
);

  res_state_t           state_q;
  alu_result_t          m_q;
  alu_result_t          s_q;
  alu_result_t          cap;
  logic                 in_ready_q;
  logic                 sticky_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 in_xfer;
  logic                 out_xfer;

  alu_flag_gen u_flag_gen (
    .inZ        (inZ),
    .inOverFlow (inOverFlow),
    .result     (cap)
  );

  assign outValid = (state_q == ONE) || (state_q == TWO);
  assign in_xfer  = inValid & in_ready_q;
  assign out_xfer = outValid & outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            m_q     <= cap;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_q <= cap;
          end else if (in_xfer) begin
            s_q        <= cap;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            m_q        <= s_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A new overflow in the same cycle as clrSticky takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (in_xfer && inOverFlow) begin
      sticky_q <= 1'b1;
    end else if (clrSticky) begin
      sticky_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_xfer && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign inReady        = in_ready_q;
  assign outZ           = m_q.z;
  assign outOverFlow    = m_q.overFlow;
  assign outZero        = m_q.zero;
  assign outNeg         = m_q.neg;
  assign stickyOverFlow = sticky_q;
  assign opCount        = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed checks of alu_result_stage against a queue-based buffer model.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid;
  logic [5:0] inZ;
  logic       inOverFlow;
  logic       outReady;
  logic       clrSticky;

  logic       inReady, outValid, outOverFlow, outZero, outNeg, stickyOverFlow;
  logic [5:0] outZ;
  logic [7:0] opCount;

  logic       s_inReady, s_outValid, s_outOverFlow, s_outZero, s_outNeg, s_sticky;
  logic [5:0] s_outZ;
  logic [1:0] s_opCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] z;
    logic       ovf;
  } word_t;

  word_t mq[$];
  logic  m_sticky;
  int    m_cnt;
  int    m_cnt_sat;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(6), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .inZ(inZ),
    .inOverFlow(inOverFlow), .outValid(outValid), .outReady(outReady), .outZ(outZ),
    .outOverFlow(outOverFlow), .outZero(outZero), .outNeg(outNeg), .clrSticky(clrSticky),
    .stickyOverFlow(stickyOverFlow), .opCount(opCount)
  );

  alu_result_stage #(.WIDTH(6), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(s_inReady), .inZ(inZ),
    .inOverFlow(inOverFlow), .outValid(s_outValid), .outReady(outReady), .outZ(s_outZ),
    .outOverFlow(s_outOverFlow), .outZero(s_outZero), .outNeg(s_outNeg), .clrSticky(clrSticky),
    .stickyOverFlow(s_sticky), .opCount(s_opCount)
  );

  task automatic model_reset();
    mq.delete();
    m_sticky  = 1'b0;
    m_cnt     = 0;
    m_cnt_sat = 0;
  endtask

  // One clock: drive inputs at the falling edge, update the model at the rising edge.
  task automatic cycle(input logic v, input logic [5:0] z, input logic o,
                       input logic r, input logic c);
    bit    in_acc, out_acc;
    word_t w;
    inValid = v; inZ = z; inOverFlow = o; outReady = r; clrSticky = c;
    in_acc  = v && (mq.size() < 2);
    out_acc = (mq.size() > 0) && r;
    @(posedge clk);
    if (out_acc) begin
      void'(mq.pop_front());
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_sat < 3) m_cnt_sat++;
    end
    if (in_acc) begin
      w.z = z; w.ovf = o;
      mq.push_back(w);
    end
    if (in_acc && o) m_sticky = 1'b1;
    else if (c) m_sticky = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inValid = 0; inZ = 0; inOverFlow = 0; outReady = 0; clrSticky = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b expected 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
    checks++; if ({outZ, outOverFlow, outZero, outNeg} !== 9'h0) begin errors++;
      $display("FAIL reset_outputs: got z=%h ovf=%b zero=%b neg=%b expected all 0", outZ, outOverFlow, outZero, outNeg); end
    checks++; if (stickyOverFlow !== 1'b0 || opCount !== 8'd0) begin errors++;
      $display("FAIL reset_sticky_cnt: got sticky=%b cnt=%0d expected 0/0", stickyOverFlow, opCount); end
    rst_n = 1'b1;
    @(negedge clk);
    // Fill to two entries with a drained word counted, then reset mid-cycle.
    cycle(1'b1, 6'h11, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 6'h12, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 6'h13, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'h14, 1'b0, 1'b0, 1'b0);
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL pre_reset_full: got inReady=%b expected 0", inReady); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (inReady !== 1'b1 || outValid !== 1'b0) begin errors++;
      $display("FAIL midreset_handshake: got inReady=%b outValid=%b expected 1/0", inReady, outValid); end
    checks++; if (opCount !== 8'd0 || stickyOverFlow !== 1'b0 || outZ !== 6'h00) begin errors++;
      $display("FAIL midreset_state: got cnt=%0d sticky=%b z=%h expected 0/0/00", opCount, stickyOverFlow, outZ); end
    inValid = 1'b0; outReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    cycle(1'b1, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b1 || outZero !== 1'b1 || outNeg !== 1'b0 || outZ !== 6'h00) begin errors++;
      $display("FAIL single_word: got v=%b zero=%b neg=%b z=%h expected 1/1/0/00", outValid, outZero, outNeg, outZ); end
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (opCount !== 8'(m_cnt) || m_cnt != 1) begin errors++;
      $display("FAIL single_count: got %0d expected 1", opCount); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_empty: got outValid=%b expected 0", outValid); end
  endtask

  task automatic test_stream();
    int base;
    base = m_cnt;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 6'(i), 1'b0, 1'b1, 1'b0);
      checks++; if (outValid !== 1'b1 || outZ !== 6'(i) || inReady !== 1'b1) begin errors++;
        $display("FAIL stream_word%0d: got v=%b z=%h rdy=%b expected 1/%h/1", i, outValid, outZ, inReady, 6'(i)); end
    end
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (opCount !== 8'(base + 8)) begin errors++;
      $display("FAIL stream_count: got %0d expected %0d", opCount, base + 8); end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 6'h21, 1'b0, 1'b0, 1'b0);
    checks++; if (outZ !== 6'h21 || outNeg !== 1'b1 || inReady !== 1'b1) begin errors++;
      $display("FAIL bp_first: got z=%h neg=%b rdy=%b expected 21/1/1", outZ, outNeg, inReady); end
    cycle(1'b1, 6'h3F, 1'b0, 1'b0, 1'b0);
    checks++; if (inReady !== 1'b0 || outZ !== 6'h21) begin errors++;
      $display("FAIL bp_full: got rdy=%b z=%h expected 0/21", inReady, outZ); end
    cycle(1'b1, 6'h05, 1'b0, 1'b0, 1'b0);
    checks++; if (inReady !== 1'b0 || outZ !== 6'h21 || outValid !== 1'b1) begin errors++;
      $display("FAIL bp_hold: got rdy=%b z=%h v=%b expected 0/21/1", inReady, outZ, outValid); end
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (outZ !== 6'h3F || outNeg !== 1'b1 || inReady !== 1'b1) begin errors++;
      $display("FAIL bp_second: got z=%h neg=%b rdy=%b expected 3f/1/1", outZ, outNeg, inReady); end
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_drained: got outValid=%b expected 0", outValid); end
  endtask

  task automatic test_sticky();
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    checks++; if (stickyOverFlow !== 1'b0) begin errors++; $display("FAIL sticky_clear0: got %b expected 0", stickyOverFlow); end
    cycle(1'b1, 6'h01, 1'b1, 1'b1, 1'b0);
    checks++; if (stickyOverFlow !== 1'b1 || outOverFlow !== 1'b1) begin errors++;
      $display("FAIL sticky_set: got sticky=%b ovf=%b expected 1/1", stickyOverFlow, outOverFlow); end
    cycle(1'b1, 6'h02, 1'b1, 1'b1, 1'b1);
    checks++; if (stickyOverFlow !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b expected 1", stickyOverFlow); end
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    checks++; if (stickyOverFlow !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", stickyOverFlow); end
  endtask

  task automatic test_random();
    logic       exp_zero, exp_neg;
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      checks++; if (outValid !== (mq.size() > 0) || inReady !== (mq.size() < 2)) begin errors++;
        $display("FAIL rand_handshake@%0d: got v=%b rdy=%b expected occupancy %0d", n, outValid, inReady, mq.size()); end
      if (mq.size() > 0) begin
        exp_zero = (mq[0].z == 0);
        exp_neg  = (mq[0].z >= 32);
        checks++; if (outZ !== mq[0].z || outOverFlow !== mq[0].ovf || outZero !== exp_zero || outNeg !== exp_neg) begin errors++;
          $display("FAIL rand_data@%0d: got z=%h ovf=%b zero=%b neg=%b expected %h/%b/%b/%b",
                   n, outZ, outOverFlow, outZero, outNeg, mq[0].z, mq[0].ovf, exp_zero, exp_neg); end
      end
      checks++; if (stickyOverFlow !== m_sticky || opCount !== 8'(m_cnt) || s_opCount !== 2'(m_cnt_sat)) begin errors++;
        $display("FAIL rand_status@%0d: got sticky=%b cnt=%0d sat=%0d expected %b/%0d/%0d",
                 n, stickyOverFlow, opCount, s_opCount, m_sticky, m_cnt, m_cnt_sat); end
    end
    drain();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'(i + 7), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (s_opCount !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d expected 3", s_opCount); end
    checks++; if (opCount !== 8'd5) begin errors++; $display("FAIL sat_wide_count: got %0d expected 5", opCount); end
    cycle(1'b1, 6'h09, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (s_opCount !== 2'd3) begin errors++; $display("FAIL sat_nowrap: got %0d expected 3", s_opCount); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_sticky();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
